// File: rtl/beta_mem_pkg.sv
// Shared types for the unified instruction/data RAM arbiter.
// Holds FSM state, read-owner encodings and the default starvation limit.
package beta_mem_pkg;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_I,
    OWN_D
  } arb_owner_t;

  localparam int STARVE_LIMIT_DEF = 4;

  function automatic int starve_w(input int lim);
    return (lim < 1) ? 1 : $clog2(lim + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbiter for one single-port RAM shared by fetch (i_*) and data (d_*).
// Ports: clk/rst, fetch req/gnt/rvalid/rdata, data req/we/gnt/rvalid/
// rdata, RAM side m_*, and init_done once post-reset clearing is over.
module mem_arbiter
  import beta_mem_pkg::*;
#(
  parameter int ADDR_W         = 10,
  parameter int STARVE_LIMIT   = STARVE_LIMIT_DEF,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata,
  output logic              init_done
);

  localparam int SW = starve_w(STARVE_LIMIT);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  arb_state_t        state, state_nxt;
  arb_owner_t        owner, owner_nxt;
  logic [ADDR_W-1:0] clr_addr, clr_nxt;
  logic [SW-1:0]     starve_cnt, starve_nxt;

  logic starve_hit;
  logic fetch_win;
  logic data_win;

  // Fetch only beats data once it has waited STARVE_LIMIT cycles.
  assign starve_hit = (starve_cnt == STARVE_MAX);
  assign fetch_win  = i_req && (!d_req || starve_hit);
  assign data_win   = d_req && !fetch_win;

  always_ff @(posedge clk) begin
    if (rst) begin
      if (CLEAR_ON_RESET) begin
        state <= ST_INIT;
      end else begin
        state <= ST_RUN;
      end
      clr_addr   <= '0;
      starve_cnt <= '0;
      owner      <= OWN_NONE;
    end else begin
      state      <= state_nxt;
      clr_addr   <= clr_nxt;
      starve_cnt <= starve_nxt;
      owner      <= owner_nxt;
    end
  end

  // All combinational outputs are forced idle while rst is high, so the
  // reset cycle is quiet no matter which state the FSM was in.
  always_comb begin
    state_nxt  = state;
    clr_nxt    = clr_addr;
    starve_nxt = starve_cnt;
    owner_nxt  = OWN_NONE;
    i_gnt      = 1'b0;
    d_gnt      = 1'b0;
    m_en       = 1'b0;
    m_we       = 1'b0;
    m_addr     = '0;
    m_wdata    = '0;
    if (!rst) begin
      unique case (state)
        ST_INIT: begin
          m_en    = 1'b1;
          m_we    = 1'b1;
          m_addr  = clr_addr;
          clr_nxt = clr_addr + 1'b1;
          if (&clr_addr) begin
            state_nxt = ST_RUN;
          end
        end
        ST_RUN: begin
          i_gnt = fetch_win;
          d_gnt = data_win;
          unique case (1'b1)
            fetch_win: begin
              m_en      = 1'b1;
              m_addr    = i_addr;
              owner_nxt = OWN_I;
            end
            data_win: begin
              m_en   = 1'b1;
              m_we   = d_we;
              m_addr = d_addr;
              if (d_we) begin
                m_wdata = d_wdata;
              end else begin
                owner_nxt = OWN_D;
              end
            end
            default: ;
          endcase
          if (fetch_win) begin
            starve_nxt = '0;
          end else if (i_req && !starve_hit) begin
            starve_nxt = starve_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign init_done = (state == ST_RUN) && !rst;

  // Owner remembers who issued last cycle's read; rst drops it at once.
  assign i_rvalid = (owner == OWN_I) && !rst;
  assign d_rvalid = (owner == OWN_D) && !rst;
  assign i_rdata  = m_rdata;
  assign d_rdata  = m_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a behavioural RAM and
// a reference model of arbitration, starvation and read routing.
module tb_mem_arbiter;

  localparam int AW    = 4;
  localparam int LIM   = 4;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [31:0]   d_wdata = '0;
  logic          i_gnt, i_rvalid, d_gnt, d_rvalid;
  logic [31:0]   i_rdata, d_rdata;
  logic          m_en, m_we, init_done;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata;
  logic [31:0]   m_rdata = '0;

  logic          i_gnt0, i_rvalid0, d_gnt0, d_rvalid0;
  logic [31:0]   i_rdata0, d_rdata0;
  logic          m_en0, m_we0, init_done0;
  logic [AW-1:0] m_addr0;
  logic [31:0]   m_wdata0;

  logic          pre_fill = 1'b1;
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [31:0]   pre_data = '0;

  logic [31:0] ram [DEPTH];
  logic [31:0] ref_mem [DEPTH];

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ADDR_W(AW), .STARVE_LIMIT(LIM), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .init_done(init_done)
  );

  mem_arbiter #(.ADDR_W(AW), .STARVE_LIMIT(LIM), .CLEAR_ON_RESET(0)) dut0 (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt0),
    .i_rvalid(i_rvalid0), .i_rdata(i_rdata0),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt0), .d_rvalid(d_rvalid0), .d_rdata(d_rdata0),
    .m_en(m_en0), .m_we(m_we0), .m_addr(m_addr0), .m_wdata(m_wdata0),
    .m_rdata(32'h0), .init_done(init_done0)
  );

  // Synchronous single-port RAM with a backdoor used only while m_en=0.
  always @(posedge clk) begin
    if (pre_fill) begin
      for (int a = 0; a < DEPTH; a++) ram[a] <= 32'hFFFF_FFFF;
    end else if (pre_we) begin
      ram[pre_addr] <= pre_data;
    end else if (m_en) begin
      if (m_we) ram[m_addr] <= m_wdata;
      else m_rdata <= ram[m_addr];
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cyc();
    pre_fill = 1'b0;
    i_req = 1'b1;
    i_addr = 4'd3;
    #4;
    checks++;
    if ({i_gnt, d_gnt, i_rvalid, d_rvalid, m_en, m_we, init_done} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 0000000",
        {i_gnt, d_gnt, i_rvalid, d_rvalid, m_en, m_we, init_done});
    end
    checks++;
    if ({m_addr, m_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_bus addr %h wdata %h want 0", m_addr, m_wdata);
    end
    checks++;
    if ({init_done0, i_gnt0} !== 2'b00) begin
      errors++;
      $display("FAIL reset_noclr got %b want 00", {init_done0, i_gnt0});
    end
  endtask

  task automatic test_clear();
    cyc();
    rst = 1'b0;
    for (int k = 0; k <= DEPTH; k++) begin
      if (k > 0) cyc();
      #4;
      if (k == 0) begin
        checks++;
        if ({init_done0, i_gnt0} !== 2'b11) begin
          errors++;
          $display("FAIL noclr_first got %b want 11", {init_done0, i_gnt0});
        end
      end
      if (k < DEPTH) begin
        checks++;
        if ({m_en, m_we, i_gnt, d_gnt, init_done} !== 5'b11000 ||
            m_addr !== AW'(k) || m_wdata !== 32'h0) begin
          errors++;
          $display("FAIL clear_%0d ctl %b addr %h wd %h want 11000 %h 0", k,
            {m_en, m_we, i_gnt, d_gnt, init_done}, m_addr, m_wdata, AW'(k));
        end
      end else begin
        checks++;
        if ({init_done, i_gnt, m_en, m_we} !== 4'b1110 || m_addr !== 4'd3) begin
          errors++;
          $display("FAIL clear_done got %b addr %h want 1110 3",
            {init_done, i_gnt, m_en, m_we}, m_addr);
        end
      end
    end
    cyc();
    i_req = 1'b0;
    #4;
    checks++;
    if (i_rvalid !== 1'b1 || i_rdata !== 32'h0) begin
      errors++;
      $display("FAIL clear_read rv %b data %h want 1 0", i_rvalid, i_rdata);
    end
    for (int a = 0; a < DEPTH; a++) ref_mem[a] = 32'h0;
  endtask

  task automatic test_simple_read();
    cyc();
    pre_we = 1'b1;
    pre_addr = 4'd5;
    pre_data = 32'hDEAD_BEEF;
    ref_mem[5] = 32'hDEAD_BEEF;
    #4;
    checks++;
    if (m_en !== 1'b0) begin
      errors++;
      $display("FAIL idle_en got %b want 0", m_en);
    end
    cyc();
    pre_we = 1'b0;
    i_req = 1'b1;
    i_addr = 4'd5;
    #4;
    checks++;
    if ({i_gnt, d_gnt, m_en, m_we} !== 4'b1010 || m_addr !== 4'd5) begin
      errors++;
      $display("FAIL sread_gnt got %b addr %h want 1010 5",
        {i_gnt, d_gnt, m_en, m_we}, m_addr);
    end
    cyc();
    i_req = 1'b0;
    #4;
    checks++;
    if ({i_rvalid, d_rvalid} !== 2'b10 || i_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL sread_data rv %b data %h want 10 deadbeef",
        {i_rvalid, d_rvalid}, i_rdata);
    end
  endtask

  task automatic test_write_read();
    cyc();
    d_req = 1'b1;
    d_we = 1'b1;
    d_addr = 4'd7;
    d_wdata = 32'h1234_5678;
    #4;
    checks++;
    if ({i_gnt, d_gnt, m_en, m_we} !== 4'b0111 || m_addr !== 4'd7 ||
        m_wdata !== 32'h1234_5678) begin
      errors++;
      $display("FAIL wr_gnt got %b addr %h wd %h want 0111 7 12345678",
        {i_gnt, d_gnt, m_en, m_we}, m_addr, m_wdata);
    end
    cyc();
    d_we = 1'b0;
    ref_mem[7] = 32'h1234_5678;
    #4;
    checks++;
    if ({d_gnt, m_en, m_we, d_rvalid, i_rvalid} !== 5'b11000) begin
      errors++;
      $display("FAIL rd_gnt got %b want 11000",
        {d_gnt, m_en, m_we, d_rvalid, i_rvalid});
    end
    cyc();
    d_req = 1'b0;
    #4;
    checks++;
    if ({d_rvalid, i_rvalid} !== 2'b10 || d_rdata !== 32'h1234_5678) begin
      errors++;
      $display("FAIL wr_rd_data rv %b data %h want 10 12345678",
        {d_rvalid, i_rvalid}, d_rdata);
    end
  endtask

  task automatic test_starve();
    logic exp_i;
    cyc();
    i_req = 1'b1;
    d_req = 1'b1;
    d_we = 1'b0;
    i_addr = 4'd1;
    d_addr = 4'd2;
    for (int p = 0; p < 15; p++) begin
      if (p > 0) cyc();
      #4;
      exp_i = ((p % (LIM + 1)) == LIM);
      checks++;
      if ({i_gnt, d_gnt} !== {exp_i, ~exp_i}) begin
        errors++;
        $display("FAIL starve_%0d got %b want %b", p,
          {i_gnt, d_gnt}, {exp_i, ~exp_i});
      end
    end
    cyc();
    i_req = 1'b0;
    d_req = 1'b0;
    #4;
    checks++;
    if ({i_rvalid, d_rvalid} !== 2'b10 || i_rdata !== ref_mem[1]) begin
      errors++;
      $display("FAIL starve_tail rv %b data %h want 10 %h",
        {i_rvalid, d_rvalid}, i_rdata, ref_mem[1]);
    end
  endtask

  task automatic test_random();
    int wait_i = 0;
    logic gi = 1'b0, gd = 1'b0;
    logic fw, dw, eiv = 1'b0, edv = 1'b0;
    logic [31:0] erd = '0;
    for (int n = 0; n < 400; n++) begin
      cyc();
      if (!i_req || gi) begin
        i_req = 1'($urandom_range(0, 1));
        i_addr = AW'($urandom);
      end
      if (!d_req || gd) begin
        d_req = 1'($urandom_range(0, 1));
        d_we = 1'($urandom_range(0, 1));
        d_addr = AW'($urandom);
        d_wdata = $urandom;
      end
      fw = i_req && (!d_req || wait_i >= LIM);
      dw = d_req && !fw;
      #4;
      checks++;
      if ({i_gnt, d_gnt, m_en} !== {fw, dw, fw | dw}) begin
        errors++;
        $display("FAIL rnd_gnt_%0d got %b want %b", n,
          {i_gnt, d_gnt, m_en}, {fw, dw, fw | dw});
      end
      if (fw || dw) begin
        checks++;
        if (m_we !== (dw && d_we) || m_addr !== (fw ? i_addr : d_addr) ||
            (dw && d_we && m_wdata !== d_wdata)) begin
          errors++;
          $display("FAIL rnd_bus_%0d we %b addr %h wd %h", n,
            m_we, m_addr, m_wdata);
        end
      end
      checks++;
      if ({i_rvalid, d_rvalid} !== {eiv, edv} ||
          (eiv && i_rdata !== erd) || (edv && d_rdata !== erd)) begin
        errors++;
        $display("FAIL rnd_rd_%0d rv %b i %h d %h want %b %h", n,
          {i_rvalid, d_rvalid}, i_rdata, d_rdata, {eiv, edv}, erd);
      end
      eiv = fw;
      edv = dw && !d_we;
      erd = fw ? ref_mem[i_addr] : ref_mem[d_addr];
      if (dw && d_we) ref_mem[d_addr] = d_wdata;
      if (fw) wait_i = 0;
      else if (i_req && wait_i < LIM) wait_i++;
      gi = fw;
      gd = dw;
    end
    cyc();
    i_req = 1'b0;
    d_req = 1'b0;
    #4;
    checks++;
    if ({i_rvalid, d_rvalid} !== {eiv, edv} ||
        ((eiv || edv) && m_rdata !== erd)) begin
      errors++;
      $display("FAIL rnd_tail rv %b data %h want %b %h",
        {i_rvalid, d_rvalid}, m_rdata, {eiv, edv}, erd);
    end
  endtask

  task automatic test_reset_drop();
    cyc();
    i_req = 1'b1;
    i_addr = 4'd2;
    #4;
    checks++;
    if (i_gnt !== 1'b1) begin
      errors++;
      $display("FAIL drop_gnt got %b want 1", i_gnt);
    end
    cyc();
    i_req = 1'b0;
    rst = 1'b1;
    #4;
    checks++;
    if ({i_rvalid, d_rvalid, m_en, init_done} !== 4'b0) begin
      errors++;
      $display("FAIL drop_rst got %b want 0000",
        {i_rvalid, d_rvalid, m_en, init_done});
    end
    cyc();
    rst = 1'b0;
    #4;
    checks++;
    if ({i_rvalid, m_en, m_we} !== 3'b011 || m_addr !== 4'd0) begin
      errors++;
      $display("FAIL drop_after got %b addr %h want 011 0",
        {i_rvalid, m_en, m_we}, m_addr);
    end
  endtask

  task automatic test_mid_clear();
    for (int k = 1; k <= 8; k++) begin
      cyc();
      #4;
      checks++;
      if (m_en !== 1'b1 || m_addr !== AW'(k)) begin
        errors++;
        $display("FAIL mid_pre_%0d en %b addr %h", k, m_en, m_addr);
      end
    end
    cyc();
    rst = 1'b1;
    #4;
    checks++;
    if ({m_en, init_done} !== 2'b00) begin
      errors++;
      $display("FAIL mid_rst got %b want 00", {m_en, init_done});
    end
    cyc();
    rst = 1'b0;
    for (int k = 0; k <= DEPTH; k++) begin
      if (k > 0) cyc();
      #4;
      if (k < DEPTH) begin
        checks++;
        if ({m_en, m_we, init_done} !== 3'b110 || m_addr !== AW'(k)) begin
          errors++;
          $display("FAIL mid_clr_%0d got %b addr %h want 110 %h", k,
            {m_en, m_we, init_done}, m_addr, AW'(k));
        end
      end else begin
        checks++;
        if ({init_done, m_en, i_gnt} !== 3'b100) begin
          errors++;
          $display("FAIL mid_done got %b want 100", {init_done, m_en, i_gnt});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_simple_read();
    test_write_read();
    test_starve();
    test_random();
    test_reset_drop();
    test_mid_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
